// File: rtl/traffic_pkg.sv
// traffic_pkg: shared phase encodings, direction codes and lamp helpers
package traffic_pkg;
   localparam int LAMP_W = 4;
   typedef enum logic [1:0] {ST_ALL_RED = 2'd0, ST_GREEN = 2'd1, ST_YELLOW = 2'd2} phase_t;
   typedef enum logic [1:0] {DIR_N = 2'd0, DIR_E = 2'd1, DIR_S = 2'd2, DIR_W = 2'd3} dir_t;
   function automatic logic [LAMP_W-1:0] dir_mask(input logic [1:0] d);
      return LAMP_W'(1) << d;
   endfunction
   function automatic logic [7:0] at_least_one(input logic [7:0] d);
      return d == 8'd0 ? 8'd1 : d;
   endfunction
endpackage

// File: rtl/phase_request_scheduler_if.sv
// phase_request_scheduler_if: settings/requests in, lamps and status out
interface phase_request_scheduler_if;
   import traffic_pkg::*;
   logic              enable;
   logic [LAMP_W-1:0] req;
   logic              emg_req;
   logic [1:0]        emg_dir;
   logic [7:0]        green_duration;
   logic [7:0]        yellow_duration;
   logic [7:0]        red_holding;
   logic [LAMP_W-1:0] red;
   logic [LAMP_W-1:0] yellow;
   logic [LAMP_W-1:0] green;
   logic [1:0]        active_direction;
   logic [7:0]        countdown_sec;
   logic [1:0]        phase_state;
   logic [LAMP_W-1:0] pending;
   modport master (
      output enable, req, emg_req, emg_dir, green_duration, yellow_duration, red_holding,
      input  red, yellow, green, active_direction, countdown_sec, phase_state, pending
   );
   modport slave (
      input  enable, req, emg_req, emg_dir, green_duration, yellow_duration, red_holding,
      output red, yellow, green, active_direction, countdown_sec, phase_state, pending
   );
endinterface

// File: rtl/rr_arbiter4.sv
// rr_arbiter4: picks the first set request after the last grant, wrapping
module rr_arbiter4
   import traffic_pkg::*;
(
   input  logic [LAMP_W-1:0] request,
   input  logic [1:0]        last,
   output logic [1:0]        grant,
   output logic              valid
);
   // offsets scanned from farthest to nearest so the nearest hit wins
   always_comb begin
      grant = last + 2'd1;
      valid = 1'b0;
      for (int i = 4; i >= 1; i--)
         if (request[2'(last + 2'(i))]) begin
            grant = 2'(last + 2'(i));
            valid = 1'b1;
         end
   end
endmodule

// File: rtl/phase_request_scheduler.sv
// phase_request_scheduler: round-robin GREEN/YELLOW/ALL_RED phase sequencer
module phase_request_scheduler
   import traffic_pkg::*;
#(
   parameter int TICKS_PER_SEC = 100_000_000
)
(
   input logic                     clk,
   input logic                     reset,
   phase_request_scheduler_if.slave bus
);
   localparam int PW = TICKS_PER_SEC > 1 ? $clog2(TICKS_PER_SEC) : 1;
   phase_t            state_q, state_d;
   logic [PW-1:0]     presc_q, presc_d;
   logic [7:0]        count_q, count_d;
   logic [1:0]        dir_q, dir_d, grant, arb_grant;
   logic [LAMP_W-1:0] pending_q, pending_d;
   logic [LAMP_W-1:0] red_q, red_d, yellow_q, yellow_d, green_q, green_d;
   logic              arb_valid, tick, hold, preempt, leave, serve;
   rr_arbiter4 u_arb (
      .request (pending_q),
      .last    (dir_q),
      .grant   (arb_grant),
      .valid   (arb_valid)
   );
   // next phase, timing, grant and lamp decode; every field holds while disabled
   always_comb begin
      tick      = presc_q == PW'(TICKS_PER_SEC - 1);
      hold      = state_q == ST_GREEN && bus.emg_req && bus.emg_dir == dir_q;
      preempt   = state_q == ST_GREEN && bus.emg_req && bus.emg_dir != dir_q;
      leave     = bus.enable && (preempt || (!hold && tick && count_q == 8'd1));
      serve     = leave && state_q == ST_ALL_RED;
      state_d   = !leave ? state_q :
                  state_q == ST_GREEN  ? ST_YELLOW :
                  state_q == ST_YELLOW ? ST_ALL_RED : ST_GREEN;
      grant     = bus.emg_req ? bus.emg_dir : arb_valid ? arb_grant : dir_q + 2'd1;
      dir_d     = serve ? grant : dir_q;
      pending_d = !bus.enable ? pending_q :
                  (pending_q | bus.req) & ~(serve ? dir_mask(grant) : '0);
      presc_d   = !bus.enable || hold ? presc_q : leave || tick ? '0 : presc_q + PW'(1);
      count_d   = leave ? at_least_one(state_d == ST_GREEN  ? bus.green_duration :
                                       state_d == ST_YELLOW ? bus.yellow_duration :
                                       bus.red_holding) :
                  bus.enable && !hold && tick ? count_q - 8'd1 : count_q;
      red_d     = state_d == ST_ALL_RED ? '1 : ~dir_mask(dir_d);
      yellow_d  = state_d == ST_YELLOW ? dir_mask(dir_d) : '0;
      green_d   = state_d == ST_GREEN ? dir_mask(dir_d) : '0;
   end
   // state and registered outputs, async clear to the all-red idle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_ALL_RED;
         presc_q   <= '0;
         count_q   <= 8'd1;
         dir_q     <= DIR_W;
         pending_q <= '0;
         red_q     <= '1;
         yellow_q  <= '0;
         green_q   <= '0;
      end else begin
         state_q   <= state_d;
         presc_q   <= presc_d;
         count_q   <= count_d;
         dir_q     <= dir_d;
         pending_q <= pending_d;
         red_q     <= red_d;
         yellow_q  <= yellow_d;
         green_q   <= green_d;
      end
   end
   assign bus.red              = red_q;
   assign bus.yellow           = yellow_q;
   assign bus.green            = green_q;
   assign bus.active_direction = dir_q;
   assign bus.countdown_sec    = count_q;
   assign bus.phase_state      = state_q;
   assign bus.pending          = pending_q;
endmodule

// File: tb/tb_phase_request_scheduler.sv
// tb_phase_request_scheduler: directed scenarios plus random traffic against a cycle-budget model
module tb_phase_request_scheduler;
   localparam int T = 4;
   localparam int PH_RED = 0, PH_GREEN = 1, PH_YELLOW = 2;
   logic clk = 1'b0;
   logic reset;
   int   n_tests = 0, n_fail = 0;
   int   m_phase, m_dir, m_rem;
   logic [3:0] m_pend;
   logic [7:0] saved;
   always #5 clk = ~clk;
   phase_request_scheduler_if bus ();
   phase_request_scheduler #(.TICKS_PER_SEC(T)) dut (.clk(clk), .reset(reset), .bus(bus));
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask
   function automatic int budget(input logic [7:0] secs);
      return (secs == 8'd0 ? 1 : int'(secs)) * T;
   endfunction
   task automatic model_reset();
      m_phase = PH_RED; m_dir = 3; m_rem = T; m_pend = 4'b0;
   endtask
   task automatic model_enter(input int ph);
      m_phase = ph;
      m_rem = ph == PH_GREEN ? budget(bus.green_duration) :
              ph == PH_YELLOW ? budget(bus.yellow_duration) : budget(bus.red_holding);
   endtask
   task automatic model_step();
      logic [3:0] old_pend;
      int g;
      if (!bus.enable) return;
      old_pend = m_pend;
      m_pend = m_pend | bus.req;
      if (m_phase == PH_GREEN && bus.emg_req && int'(bus.emg_dir) != m_dir) begin
         model_enter(PH_YELLOW);
      end else if (!(m_phase == PH_GREEN && bus.emg_req)) begin
         m_rem--;
         if (m_rem == 0) begin
            if (m_phase == PH_GREEN) model_enter(PH_YELLOW);
            else if (m_phase == PH_YELLOW) model_enter(PH_RED);
            else begin
               g = (m_dir + 1) % 4;
               if (bus.emg_req) g = int'(bus.emg_dir);
               else if (old_pend != 0)
                  for (int k = 4; k >= 1; k--) if (old_pend[(m_dir + k) % 4]) g = (m_dir + k) % 4;
               m_dir = g;
               m_pend[g] = 1'b0;
               model_enter(PH_GREEN);
            end
         end
      end
   endtask
   task automatic compare();
      logic [3:0] er, ey, eg;
      for (int d = 0; d < 4; d++) begin
         eg[d] = m_phase == PH_GREEN && d == m_dir;
         ey[d] = m_phase == PH_YELLOW && d == m_dir;
         er[d] = !(eg[d] || ey[d]);
      end
      check("red", bus.red, er);
      check("yellow", bus.yellow, ey);
      check("green", bus.green, eg);
      check("phase", bus.phase_state, m_phase);
      check("active_dir", bus.active_direction, m_dir);
      check("countdown", bus.countdown_sec, (m_rem + T - 1) / T);
      check("pending", bus.pending, m_pend);
   endtask
   task automatic cycle();
      @(posedge clk);
      model_step();
      #1 compare();
   endtask
   task automatic run(input int n);
      for (int k = 0; k < n; k++) cycle();
   endtask
   task automatic wait_phase(input int ph, input int lim);
      int n;
      n = 0;
      while (int'(bus.phase_state) != ph && n < lim) begin cycle(); n++; end
      check("reach_phase", bus.phase_state, ph);
   endtask
   initial begin
      reset = 1'b1;
      bus.enable = 1'b1; bus.req = 4'b0; bus.emg_req = 1'b0; bus.emg_dir = 2'd0;
      bus.green_duration = 8'd3; bus.yellow_duration = 8'd1; bus.red_holding = 8'd1;
      model_reset();
      #1 compare();
      check("rst_red", bus.red, 4'b1111);
      check("rst_cd", bus.countdown_sec, 8'd1);
      @(negedge clk);
      reset = 1'b0;
      run(4);
      check("first_green", bus.green, 4'b0001);
      check("first_cd", bus.countdown_sec, 8'd3);
      run(12);
      check("first_yellow", bus.yellow, 4'b0001);
      run(4);
      check("first_allred", bus.red, 4'b1111);
      run(4);
      check("second_green", bus.green, 4'b0010);
      bus.req = 4'b1000;
      cycle();
      bus.req = 4'b0;
      check("pend_latch", bus.pending, 4'b1000);
      wait_phase(PH_RED, 100);
      wait_phase(PH_GREEN, 100);
      check("skip_to_w", bus.green, 4'b1000);
      check("pend_clear", bus.pending, 4'b0000);
      bus.emg_req = 1'b1; bus.emg_dir = 2'd1;
      cycle();
      check("emg_yellow", bus.yellow, 4'b1000);
      check("emg_ycd", bus.countdown_sec, 8'd1);
      wait_phase(PH_RED, 100);
      wait_phase(PH_GREEN, 100);
      check("emg_green", bus.green, 4'b0010);
      saved = bus.countdown_sec;
      run(10);
      check("emg_freeze", bus.countdown_sec, saved);
      bus.emg_req = 1'b0;
      bus.green_duration = 8'd0;
      run(5);
      wait_phase(PH_RED, 100);
      wait_phase(PH_GREEN, 100);
      check("g0_cd", bus.countdown_sec, 8'd1);
      run(3);
      check("g0_still", bus.phase_state, PH_GREEN);
      cycle();
      check("g0_exit", bus.phase_state, PH_YELLOW);
      bus.green_duration = 8'd2;
      bus.yellow_duration = 8'd3;
      wait_phase(PH_RED, 100);
      wait_phase(PH_GREEN, 100);
      wait_phase(PH_YELLOW, 100);
      run(2);
      saved = bus.countdown_sec;
      bus.enable = 1'b0;
      bus.req = 4'b1111;
      run(10);
      check("frz_cd", bus.countdown_sec, saved);
      check("frz_pend", bus.pending, 4'b0);
      bus.enable = 1'b1;
      bus.req = 4'b0;
      wait_phase(PH_RED, 100);
      wait_phase(PH_GREEN, 100);
      bus.req = 4'b0101;
      run(2);
      bus.req = 4'b0;
      #2 reset = 1'b1;
      #1 model_reset();
      compare();
      check("arst_green", bus.green, 4'b0000);
      check("arst_dir", bus.active_direction, 2'd3);
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         bus.req = $urandom_range(0, 9) == 0 ? 4'($urandom) : 4'b0;
         if ($urandom_range(0, 49) == 0) bus.emg_req = ~bus.emg_req;
         if ($urandom_range(0, 29) == 0) bus.emg_dir = 2'($urandom);
         bus.enable = $urandom_range(0, 19) != 0;
         if ($urandom_range(0, 99) == 0) begin
            bus.green_duration = 8'($urandom_range(0, 3));
            bus.yellow_duration = 8'($urandom_range(0, 2));
            bus.red_holding = 8'($urandom_range(0, 2));
         end
         cycle();
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/phase_request_scheduler.md
Name: phase_request_scheduler

Overview:
Round-robin phase scheduler that decides which approach (N/E/S/W) receives the intersection next.
- Sequences GREEN -> YELLOW -> ALL_RED per phase, with durations taken from the menu-controlled settings.
- Latches per-direction vehicle/pedestrian requests and skips directions with no demand.
- Supports emergency preemption.
- Drives lamp vectors, active_direction and countdown_sec for the shape renderer and the text renderer.

Parameters:
TICKS_PER_SEC, 100_000_000, clk cycles per one-second tick (benches use 4)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  1 = run; 0 = freeze all state and counters
req  in  4  per-direction request level; bit0=N, 1=E, 2=S, 3=W
emg_req  in  1  emergency preemption request (level)
emg_dir  in  2  direction to serve during emergency
green_duration  in  8  green time, seconds
yellow_duration  in  8  yellow time, seconds
red_holding  in  8  all-red clearance time, seconds
red  out  4  per-direction red lamp
yellow  out  4  per-direction yellow lamp
green  out  4  per-direction green lamp
active_direction  out  2  direction currently or last granted
countdown_sec  out  8  seconds remaining in current state
phase_state  out  2  0=ALL_RED, 1=GREEN, 2=YELLOW
pending  out  4  latched unserved requests

Behaviour:
- Outputs: all registered, updated on the same clk edge as the state.
- Reset values: state ALL_RED; red=4'b1111; yellow=0; green=0; active_direction=3; countdown_sec=1; pending=0; prescaler=0.
- Reset mid-operation: reset takes effect immediately and asynchronously, regardless of enable.
- Prescaler: counts 0..TICKS_PER_SEC-1 while enable=1. A tick occurs on wrap. The prescaler is cleared on every state entry, so a state lasting D seconds lasts exactly D*TICKS_PER_SEC cycles.
- State entry: countdown_sec is loaded with the duration for the new state (green, yellow or red_holding) sampled on that cycle. A duration of 0 is treated as 1. Changing a setting mid-state has no effect until the next entry.
- Countdown: each tick decrements countdown_sec. A tick with countdown_sec==1 exits the state instead of decrementing, so the display shows D..1.
- Transitions: GREEN -> YELLOW -> ALL_RED -> GREEN(next grant).
- Grant, decided on the ALL_RED exit tick:
  - emg_req=1: grant emg_dir.
  - else pending!=0: round-robin search starting at (active_direction+1) mod 4, first set bit wins.
  - else: grant (active_direction+1) mod 4 (default rotation).
- Request latch: pending[i] |= req[i] every enabled cycle, visible the next cycle. pending[i] clears on the cycle direction i enters GREEN. If req[i] is high on that same cycle, the clear wins.
- Lamps:
  - Active direction: green in GREEN, yellow in YELLOW.
  - All other directions: red.
  - ALL_RED state: red=1111.
  - Exactly one lamp is lit per direction at all times.
- Emergency preemption:
  - emg_req=1 in GREEN with active_direction!=emg_dir: enter YELLOW on the next edge (countdown reloads yellow_duration), then ALL_RED, then grant emg_dir.
  - emg_req=1 in GREEN with active_direction==emg_dir: stay in GREEN with prescaler and countdown frozen. When emg_req falls, timing resumes from the frozen value.
  - emg_req in YELLOW/ALL_RED: the state completes normally.
- enable=0: state, prescaler, countdown and pending all hold; lamps unchanged; req ignored.

Decomposition:
- Shared package traffic_pkg holds:
  - state encodings ST_ALL_RED/ST_GREEN/ST_YELLOW;
  - direction codes DIR_N=0, DIR_E=1, DIR_S=2, DIR_W=3;
  - lamp vector width 4.
- One sub-module: rr_arbiter4.
  - Combinational; inputs: 4-bit request and 2-bit last grant.
  - Outputs: 2-bit grant and valid.
  - Search starts at last+1 mod 4.
- Prescaler and countdown stay in phase_request_scheduler.

Test Plan:
All scenarios use TICKS_PER_SEC=4.
- Reset, enable=1, req=0, G=3/Y=1/R=1 -> after 4 cycles green=0001 with countdown 3. After 12 more cycles yellow=0001 (4 cycles), then red=1111 (4 cycles), then green=0010.
- During N green, 1-cycle pulse on req[2] -> pending=0100 next cycle. Next grant is S (green=0100), skipping E. pending[2] clears on the S green entry.
- During N green at countdown 3, emg_req=1, emg_dir=3 -> next cycle yellow=0001 with countdown 1, then ALL_RED, then green=1000. green=1000 holds with countdown frozen while emg_req=1, and resumes counting after emg_req drops.
- green_duration=0 -> GREEN lasts exactly 4 cycles with countdown showing 1.
- enable=0 for 10 cycles mid-YELLOW -> all outputs constant. After re-enable, the remaining prescaler cycles complete before the exit.
- reset pulse mid-GREEN, without waiting for a clock edge -> red=1111, green=0, countdown_sec=1, pending=0, active_direction=3.
